rx_cmd_decoder: RTL and testbench
=================================

RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 SHALL have parameter Data_width, default 8, meaning received byte and register-file data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning register-file address width (16 entries).
REQ-003 SHALL have parameter FUN_WIDTH, default 4, meaning ALU function code width.
REQ-004 SHALL have port CLK, input, 1, meaning the single block clock (REF_CLK domain).
REQ-005 SHALL have port RST, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port RX_P_DATA, input, Data_width, meaning synchronized received byte.
REQ-007 SHALL have port RX_D_VLD, input, 1, meaning one-cycle pulse qualifying RX_P_DATA.
REQ-008 SHALL have port RdData_Valid, input, 1, meaning register-file read data returned.
REQ-009 SHALL have port ALU_OUT_VLD, input, 1, meaning ALU result valid.
REQ-010 SHALL have port Address, output, ADDR_WIDTH, meaning register-file address.
REQ-011 SHALL have port WrEn, output, 1, meaning register-file write strobe.
REQ-012 SHALL have port RdEn, output, 1, meaning register-file read strobe.
REQ-013 SHALL have port WrData, output, Data_width, meaning register-file write data.
REQ-014 SHALL have port ALU_EN, output, 1, meaning ALU start strobe.
REQ-015 SHALL have port ALU_FUN, output, FUN_WIDTH, meaning ALU operation select.
REQ-016 SHALL have port CLK_EN, output, 1, meaning ALU clock-gate enable.
REQ-017 SHALL have port DROP_CNT, output, 8, meaning count of discarded bytes.

Function
REQ-018 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN_S, ALU_WAIT; FSM advances only on RX_D_VLD except the wait states.
REQ-019 SHALL, in IDLE on RX_D_VLD, go to WR_ADDR for 0xAA, RD_ADDR for 0xBB, ALU_A for 0xCC, ALU_FUN_S for 0xDD; any other byte stays IDLE and increments DROP_CNT.
REQ-020 SHALL latch RX_P_DATA[ADDR_WIDTH-1:0] in WR_ADDR, then in WR_DATA pulse WrEn for exactly one cycle with latched Address and WrData=byte, return IDLE.
REQ-021 SHALL, in RD_ADDR, pulse RdEn one cycle with Address=byte[ADDR_WIDTH-1:0], enter RD_WAIT, return IDLE on RdData_Valid.
REQ-022 SHALL write ALU_A byte to address 0x0 and ALU_B byte to address 0x1 via one-cycle WrEn pulses.
REQ-023 SHALL, in ALU_FUN_S, drive ALU_FUN=byte[FUN_WIDTH-1:0], pulse ALU_EN one cycle, enter ALU_WAIT, return IDLE on ALU_OUT_VLD.
REQ-024 SHALL assert CLK_EN from the cycle ALU_EN is asserted until the cycle after ALU_OUT_VLD, low otherwise.
REQ-025 SHALL register all outputs; every strobe appears exactly one cycle after the qualifying RX_D_VLD cycle.
REQ-026 SHALL discard RX_D_VLD bytes received in RD_WAIT or ALU_WAIT and increment DROP_CNT; DROP_CNT saturates at 0xFF.
REQ-027 SHALL give RdData_Valid/ALU_OUT_VLD priority over a simultaneous RX_D_VLD (byte dropped, counted).
REQ-028 SHALL hold Address, WrData, ALU_FUN stable between strobes; WrEn, RdEn, ALU_EN never assert together.
REQ-029 SHALL ignore RdData_Valid/ALU_OUT_VLD outside their wait states.

Reset
REQ-030 SHALL, on RST low, immediately force state IDLE and all outputs (Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, DROP_CNT) to zero, including mid-command; the partial command is abandoned.
REQ-031 SHALL resume byte decoding on the first RX_D_VLD after RST deasserts.

Structure
REQ-032 SHALL place command opcodes (0xAA, 0xBB, 0xCC, 0xDD), operand addresses (0x0, 0x1) and state encodings in shared package sys_pkg.
REQ-033 SHALL be a single module with no sub-modules; DROP_CNT saturating counter is inline.

Verification
REQ-034 SHALL verify write: bytes 0xAA, 0x01, 0x5A -> one WrEn pulse, Address=0x1, WrData=0x5A, FSM back in IDLE.
REQ-035 SHALL verify read: 0xBB, 0x01 -> one RdEn pulse Address=0x1; FSM holds RD_WAIT until RdData_Valid.
REQ-036 SHALL verify ALU: 0xCC, 0x03, 0x02, 0x00 -> WrEn to 0x0 data 0x03, WrEn to 0x1 data 0x02, ALU_EN with ALU_FUN=0x0, CLK_EN high until ALU_OUT_VLD.
REQ-037 SHALL verify no-operand ALU: 0xDD, 0x01 -> no WrEn, ALU_EN with ALU_FUN=0x1.
REQ-038 SHALL verify drops: 0x77 in IDLE, then 0xDD 0x01 plus one byte during ALU_WAIT -> DROP_CNT=2; 300 bad bytes -> DROP_CNT=0xFF.
REQ-039 SHALL verify reset after 0xAA, 0x03 (before data byte) -> all outputs zero; next 0xAA, 0x04, 0x11 writes 0x11 to 0x4 only.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared command opcodes, ALU operand addresses and decoder state encodings
// for the UART receive command path.
package sys_pkg;

  localparam logic [7:0] CMD_REG_WR  = 8'hAA;
  localparam logic [7:0] CMD_REG_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned ALU_OPA_ADDR = 0;
  localparam int unsigned ALU_OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_ADDR   = 4'd1,
    WR_DATA   = 4'd2,
    RD_ADDR   = 4'd3,
    RD_WAIT   = 4'd4,
    ALU_A     = 4'd5,
    ALU_B     = 4'd6,
    ALU_FUN_S = 4'd7,
    ALU_WAIT  = 4'd8
  } rxState_t;

endpackage

// File: rtl/rx_cmd_decoder.sv
// Decodes received command frames into register-file and ALU strobes.
// All outputs are registered, so every strobe appears one cycle after its byte.
module rx_cmd_decoder
  import sys_pkg::*;
#(
  parameter int Data_width = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_width-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RdData_Valid,
  input  logic                  ALU_OUT_VLD,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [Data_width-1:0] WrData,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_EN,
  output logic [7:0]            DROP_CNT
);

  rxState_t r_state;
  rxState_t w_nextState;

  logic [ADDR_WIDTH-1:0] r_addrLatch;
  logic [ADDR_WIDTH-1:0] w_addrLatch;
  logic [ADDR_WIDTH-1:0] w_address;
  logic [Data_width-1:0] w_wrData;
  logic [FUN_WIDTH-1:0]  w_aluFun;
  logic                  w_wrEn;
  logic                  w_rdEn;
  logic                  w_aluEn;
  logic                  w_clkEn;
  logic                  w_drop;

  // Write address is held privately so Address only moves with a strobe.
  always_comb begin
    w_nextState = r_state;
    w_addrLatch = r_addrLatch;
    w_address   = Address;
    w_wrData    = WrData;
    w_aluFun    = ALU_FUN;
    w_wrEn      = 1'b0;
    w_rdEn      = 1'b0;
    w_aluEn     = 1'b0;
    w_clkEn     = CLK_EN;
    w_drop      = 1'b0;

    case (r_state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == Data_width'(CMD_REG_WR))       w_nextState = WR_ADDR;
          else if (RX_P_DATA == Data_width'(CMD_REG_RD))  w_nextState = RD_ADDR;
          else if (RX_P_DATA == Data_width'(CMD_ALU_OP))  w_nextState = ALU_A;
          else if (RX_P_DATA == Data_width'(CMD_ALU_NOP)) w_nextState = ALU_FUN_S;
          else                                            w_drop      = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          w_addrLatch = RX_P_DATA[ADDR_WIDTH-1:0];
          w_nextState = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          w_wrEn      = 1'b1;
          w_address   = r_addrLatch;
          w_wrData    = RX_P_DATA;
          w_nextState = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          w_rdEn      = 1'b1;
          w_address   = RX_P_DATA[ADDR_WIDTH-1:0];
          w_nextState = RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_drop = RX_D_VLD;
        if (RdData_Valid) w_nextState = IDLE;
      end
      ALU_A: begin
        if (RX_D_VLD) begin
          w_wrEn      = 1'b1;
          w_address   = ADDR_WIDTH'(ALU_OPA_ADDR);
          w_wrData    = RX_P_DATA;
          w_nextState = ALU_B;
        end
      end
      ALU_B: begin
        if (RX_D_VLD) begin
          w_wrEn      = 1'b1;
          w_address   = ADDR_WIDTH'(ALU_OPB_ADDR);
          w_wrData    = RX_P_DATA;
          w_nextState = ALU_FUN_S;
        end
      end
      ALU_FUN_S: begin
        if (RX_D_VLD) begin
          w_aluEn     = 1'b1;
          w_aluFun    = RX_P_DATA[FUN_WIDTH-1:0];
          w_clkEn     = 1'b1;
          w_nextState = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        w_drop = RX_D_VLD;
        if (ALU_OUT_VLD) begin
          w_clkEn     = 1'b0;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State and every output register; reset abandons any partial command.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_addrLatch <= '0;
      Address     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_EN      <= 1'b0;
      DROP_CNT    <= 8'd0;
    end else begin
      r_state     <= w_nextState;
      r_addrLatch <= w_addrLatch;
      Address     <= w_address;
      WrEn        <= w_wrEn;
      RdEn        <= w_rdEn;
      WrData      <= w_wrData;
      ALU_EN      <= w_aluEn;
      ALU_FUN     <= w_aluFun;
      CLK_EN      <= w_clkEn;
      if (w_drop && (DROP_CNT != 8'hFF)) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: drives command byte streams and compares
// strobes, addresses, data and the drop counter against hand-worked values.
module tb_rx_cmd_decoder;
  import sys_pkg::*;

  logic       clock = 1'b0;
  logic       resetN = 1'b1;
  logic [7:0] rxData = 8'h00;
  logic       rxValid = 1'b0;
  logic       rdDataValid = 1'b0;
  logic       aluOutValid = 1'b0;
  logic [3:0] address;
  logic       wrEn;
  logic       rdEn;
  logic [7:0] wrData;
  logic       aluEn;
  logic [3:0] aluFun;
  logic       clkEn;
  logic [7:0] dropCnt;

  int checkCount = 0;
  int errorCount = 0;

  rx_cmd_decoder #(.Data_width(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
    .CLK(clock), .RST(resetN), .RX_P_DATA(rxData), .RX_D_VLD(rxValid),
    .RdData_Valid(rdDataValid), .ALU_OUT_VLD(aluOutValid),
    .Address(address), .WrEn(wrEn), .RdEn(rdEn), .WrData(wrData),
    .ALU_EN(aluEn), .ALU_FUN(aluFun), .CLK_EN(clkEn), .DROP_CNT(dropCnt)
  );

  always #5 clock = ~clock;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One byte with a single-cycle valid; returns on the negedge after the
  // capturing posedge, where the resulting strobe is visible.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clock);
    rxValid = 1'b0;
  endtask

  task automatic pulseRdValid();
    rdDataValid = 1'b1;
    @(negedge clock);
    rdDataValid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"},   32'(address), 32'h0);
    checkOutput({tag, "_wren"},   32'(wrEn),    32'h0);
    checkOutput({tag, "_rden"},   32'(rdEn),    32'h0);
    checkOutput({tag, "_wrdata"}, 32'(wrData),  32'h0);
    checkOutput({tag, "_aluen"},  32'(aluEn),   32'h0);
    checkOutput({tag, "_alufun"}, 32'(aluFun),  32'h0);
    checkOutput({tag, "_clken"},  32'(clkEn),   32'h0);
    checkOutput({tag, "_drop"},   32'(dropCnt), 32'h0);
    checkOutput({tag, "_state"},  32'(dut.r_state), 32'(IDLE));
  endtask

  initial begin
    #2 resetN = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(negedge clock);
    resetN = 1'b1;

    // Register write: AA 01 5A
    applyStimulus(8'hAA);
    checkOutput("wr_noStrobeOp", 32'(wrEn), 32'h0);
    applyStimulus(8'h01);
    checkOutput("wr_noStrobeAddr", 32'(wrEn), 32'h0);
    checkOutput("wr_addrHeld", 32'(address), 32'h0);
    applyStimulus(8'h5A);
    checkOutput("wr_wren", 32'(wrEn), 32'h1);
    checkOutput("wr_addr", 32'(address), 32'h1);
    checkOutput("wr_data", 32'(wrData), 32'h5A);
    checkOutput("wr_rdenLow", 32'(rdEn), 32'h0);
    @(negedge clock);
    checkOutput("wr_wrenOneCycle", 32'(wrEn), 32'h0);
    checkOutput("wr_idle", 32'(dut.r_state), 32'(IDLE));

    // Register read: BB 01, then wait for RdData_Valid
    applyStimulus(8'hBB);
    applyStimulus(8'h01);
    checkOutput("rd_rden", 32'(rdEn), 32'h1);
    checkOutput("rd_addr", 32'(address), 32'h1);
    checkOutput("rd_wrenLow", 32'(wrEn), 32'h0);
    repeat (3) @(negedge clock);
    checkOutput("rd_rdenOneCycle", 32'(rdEn), 32'h0);
    checkOutput("rd_waitHold", 32'(dut.r_state), 32'(RD_WAIT));
    pulseRdValid();
    checkOutput("rd_idle", 32'(dut.r_state), 32'(IDLE));

    // Strays in IDLE are ignored
    rdDataValid = 1'b1;
    aluOutValid = 1'b1;
    @(negedge clock);
    rdDataValid = 1'b0;
    aluOutValid = 1'b0;
    checkOutput("stray_idle", 32'(dut.r_state), 32'(IDLE));
    checkOutput("stray_clken", 32'(clkEn), 32'h0);

    // ALU with operands: CC 03 02 00
    applyStimulus(8'hCC);
    applyStimulus(8'h03);
    checkOutput("alu_wrenA", 32'(wrEn), 32'h1);
    checkOutput("alu_addrA", 32'(address), 32'h0);
    checkOutput("alu_dataA", 32'(wrData), 32'h03);
    applyStimulus(8'h02);
    checkOutput("alu_wrenB", 32'(wrEn), 32'h1);
    checkOutput("alu_addrB", 32'(address), 32'h1);
    checkOutput("alu_dataB", 32'(wrData), 32'h02);
    applyStimulus(8'h00);
    checkOutput("alu_aluen", 32'(aluEn), 32'h1);
    checkOutput("alu_fun", 32'(aluFun), 32'h0);
    checkOutput("alu_clkenStart", 32'(clkEn), 32'h1);
    checkOutput("alu_wrenLow", 32'(wrEn), 32'h0);
    repeat (2) @(negedge clock);
    checkOutput("alu_aluenOneCycle", 32'(aluEn), 32'h0);
    checkOutput("alu_clkenHeld", 32'(clkEn), 32'h1);
    checkOutput("alu_wait", 32'(dut.r_state), 32'(ALU_WAIT));
    aluOutValid = 1'b1;
    #1 checkOutput("alu_clkenAtVld", 32'(clkEn), 32'h1);
    @(negedge clock);
    aluOutValid = 1'b0;
    checkOutput("alu_clkenOff", 32'(clkEn), 32'h0);
    checkOutput("alu_idle", 32'(dut.r_state), 32'(IDLE));

    // Drops: 77 in IDLE, DD 01, one byte during ALU_WAIT
    applyStimulus(8'h77);
    checkOutput("drop_idle", 32'(dropCnt), 32'h1);
    applyStimulus(8'hDD);
    applyStimulus(8'h01);
    checkOutput("nop_wrenLow", 32'(wrEn), 32'h0);
    checkOutput("nop_aluen", 32'(aluEn), 32'h1);
    checkOutput("nop_fun", 32'(aluFun), 32'h1);
    applyStimulus(8'hAA);
    checkOutput("drop_aluWait", 32'(dropCnt), 32'h2);
    checkOutput("drop_stillWait", 32'(dut.r_state), 32'(ALU_WAIT));
    aluOutValid = 1'b1;
    @(negedge clock);
    aluOutValid = 1'b0;
    checkOutput("nop_idle", 32'(dut.r_state), 32'(IDLE));

    // RdData_Valid together with a byte in RD_WAIT: completion wins, byte dropped
    applyStimulus(8'hBB);
    applyStimulus(8'h02);
    @(negedge clock);
    rxData      = 8'hAA;
    rxValid     = 1'b1;
    rdDataValid = 1'b1;
    @(negedge clock);
    rxValid     = 1'b0;
    rdDataValid = 1'b0;
    checkOutput("prio_drop", 32'(dropCnt), 32'h3);
    checkOutput("prio_idle", 32'(dut.r_state), 32'(IDLE));

    // Reset mid-command after AA 03
    applyStimulus(8'hAA);
    applyStimulus(8'h03);
    #2 resetN = 1'b0;
    #1 checkAllZero("midReset");
    @(negedge clock);
    resetN = 1'b1;
    applyStimulus(8'hAA);
    checkOutput("post_noWrOp", 32'(wrEn), 32'h0);
    applyStimulus(8'h04);
    checkOutput("post_noWrAddr", 32'(wrEn), 32'h0);
    applyStimulus(8'h11);
    checkOutput("post_wren", 32'(wrEn), 32'h1);
    checkOutput("post_addr", 32'(address), 32'h4);
    checkOutput("post_data", 32'(wrData), 32'h11);
    @(negedge clock);
    checkOutput("post_wrenOneCycle", 32'(wrEn), 32'h0);

    // Saturation: 300 bad bytes
    for (int i = 0; i < 300; i++) applyStimulus(8'h77);
    checkOutput("drop_saturate", 32'(dropCnt), 32'hFF);
    checkOutput("drop_satIdle", 32'(dut.r_state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
